// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared types and constants for the seven-segment scan controller
package seg_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    localparam int NIBBLE_W = 4;

endpackage

// File: rtl/seg_refresh_timer.sv
// rtl/seg_refresh_timer.sv - slot tick counter and digit index for the scan controller
module seg_refresh_timer
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2,
    parameter int IDX_W        = $clog2(NUM_DIGITS),
    parameter int CNT_W        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic             o_slot_start,
    output logic             o_slot_end,
    output logic             o_blank_done,
    output logic             o_frame_end,
    output logic [IDX_W-1:0] o_digit_idx,
    output logic [IDX_W-1:0] o_next_idx
);

    logic [CNT_W-1:0] r_tick_cnt;
    logic [IDX_W-1:0] r_digit_idx;
    logic             w_tick_last;
    logic             w_idx_last;
    logic [IDX_W-1:0] w_next_idx;

    assign w_tick_last = (r_tick_cnt == CNT_W'(REFRESH_DIV - 1));
    assign w_idx_last  = (r_digit_idx == IDX_W'(NUM_DIGITS - 1));

    // Digit index that will be current in the next cycle
    always_comb begin
        w_next_idx = r_digit_idx;
        if (w_tick_last) begin
            w_next_idx = w_idx_last ? '0 : r_digit_idx + IDX_W'(1);
        end
    end

    // Slot counter wraps every REFRESH_DIV cycles and advances the digit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt  <= '0;
            r_digit_idx <= '0;
        end else begin
            r_tick_cnt  <= w_tick_last ? '0 : r_tick_cnt + CNT_W'(1);
            r_digit_idx <= w_next_idx;
        end
    end

    // blank_done marks the last blank cycle; with no blank interval it never fires
    generate
        if (BLANK_CYCLES > 0) begin : g_blank
            assign o_blank_done = (r_tick_cnt == CNT_W'(BLANK_CYCLES - 1)) && !w_tick_last;
        end else begin : g_no_blank
            assign o_blank_done = 1'b0;
        end
    endgenerate

    assign o_slot_start = (r_tick_cnt == '0);
    assign o_slot_end   = w_tick_last;
    assign o_frame_end  = w_tick_last && w_idx_last;
    assign o_digit_idx  = r_digit_idx;
    assign o_next_idx   = w_next_idx;

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed seven-segment scan controller (option: SEG_LZ_BLANK_EN)
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load_valid,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] load_data,
    output logic                           load_ready,
    output logic [NIBBLE_W-1:0]            dec_nibble,
    output logic [NUM_DIGITS-1:0]          digit_en,
    output logic                           frame_start
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic                           w_slot_start;
    logic                           w_slot_end;
    logic                           w_blank_done;
    logic                           w_frame_end;
    logic [IDX_W-1:0]               w_digit_idx;
    logic [IDX_W-1:0]               w_next_idx;

    scan_state_t                    r_state;
    scan_state_t                    w_next_state;
    logic [NUM_DIGITS-1:0]          r_digit_en;
    logic [NIBBLE_W*NUM_DIGITS-1:0] r_shadow;
    logic [NIBBLE_W*NUM_DIGITS-1:0] r_pending;
    logic                           r_pend_flag;
    logic [NUM_DIGITS-1:0]          w_lz_mask;
    logic [NIBBLE_W-1:0]            w_dec_nibble;

    seg_refresh_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYCLES(BLANK_CYCLES),
        .IDX_W       (IDX_W),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .o_slot_start(w_slot_start),
        .o_slot_end  (w_slot_end),
        .o_blank_done(w_blank_done),
        .o_frame_end (w_frame_end),
        .o_digit_idx (w_digit_idx),
        .o_next_idx  (w_next_idx)
    );

    // Next scan state: every slot opens blanked unless there is no blank interval
    always_comb begin
        w_next_state = r_state;
        if (w_slot_end) begin
            w_next_state = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
        end else if (w_blank_done) begin
            w_next_state = DRIVE;
        end
    end

`ifdef SEG_LZ_BLANK_EN
    // Suppressed digits: the unbroken run of zero nibbles from the top digit down, never digit 0
    always_comb begin
        logic v_zero_run;
        v_zero_run = 1'b1;
        w_lz_mask  = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            v_zero_run   = v_zero_run && (r_shadow[NIBBLE_W*i +: NIBBLE_W] == '0);
            w_lz_mask[i] = v_zero_run;
        end
    end
`else
    assign w_lz_mask = '0;
`endif

    // Scan FSM; digit_en is registered from next-cycle state so it lines up with tick_cnt
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= BLANK;
            r_digit_en <= '1;
        end else begin
            r_state <= w_next_state;
            if (w_next_state == DRIVE && !w_lz_mask[w_next_idx]) begin
                r_digit_en <= ~(NUM_DIGITS'(1) << w_next_idx);
            end else begin
                r_digit_en <= '1;
            end
        end
    end

    // Word intake and frame-boundary apply; a word can only be accepted while nothing is pending
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow    <= '0;
            r_pending   <= '0;
            r_pend_flag <= 1'b0;
        end else if (w_frame_end && r_pend_flag) begin
            r_shadow    <= r_pending;
            r_pend_flag <= 1'b0;
        end else if (load_valid && !r_pend_flag) begin
            r_pending   <= load_data;
            r_pend_flag <= 1'b1;
        end
    end

    // Select the current digit's nibble for the shared decoder
    always_comb begin
        w_dec_nibble = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_digit_idx == IDX_W'(i)) begin
                w_dec_nibble = r_shadow[NIBBLE_W*i +: NIBBLE_W];
            end
        end
    end

    assign load_ready  = !r_pend_flag;
    assign dec_nibble  = w_dec_nibble;
    assign digit_en    = r_digit_en;
    assign frame_start = w_slot_start && (w_digit_idx == '0);

endmodule
